// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory-controller port between instruction fetch and the load/store buffer
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        if_req,
  input  logic [31:0] if_a,
  output logic [63:0] if_d,
  output logic        if_ack,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic        lsb_signed,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_a,
  input  logic [31:0] lsb_din,
  output logic [31:0] lsb_dout,
  output logic        lsb_ack,
  output logic        mc_instr_signal,
  output logic [31:0] mc_instr_a,
  input  logic [63:0] mc_instr_d,
  input  logic        mc_instr_done,
  output logic        mc_lsb_signal,
  output logic        mc_lsb_wr,
  output logic        mc_lsb_signed,
  output logic [1:0]  mc_lsb_len,
  output logic [31:0] mc_lsb_a,
  output logic [31:0] mc_lsb_din,
  input  logic [31:0] mc_lsb_dout,
  input  logic        mc_lsb_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, G_IF, G_LSB, COOL} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  logic [3:0] starve_cnt;
  logic       grant_if, grant_lsb, fin_if, fin_lsb, abort;

  always_ff @(posedge clk_in) begin
    if (rst_in)
      state <= IDLE;
    else if (rdy_in)
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_lsb  = 1'b0;
    fin_if     = 1'b0;
    fin_lsb    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!clear_signal) begin
          if (if_req && (!lsb_req || starve_cnt == LIMIT)) begin
            grant_if   = 1'b1;
            state_next = G_IF;
          end else if (lsb_req) begin
            grant_lsb  = 1'b1;
            state_next = G_LSB;
          end
        end
      end
      G_IF: begin
        if (clear_signal) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (mc_instr_done) begin
          fin_if     = 1'b1;
          state_next = COOL;
        end
      end
      G_LSB: begin
        // Committed stores always run to completion, even across a flush.
        if (clear_signal && !mc_lsb_wr) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (mc_lsb_done) begin
          fin_lsb    = 1'b1;
          state_next = COOL;
        end
      end
      COOL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt      <= '0;
      if_d            <= '0;
      if_ack          <= 1'b0;
      lsb_dout        <= '0;
      lsb_ack         <= 1'b0;
      mc_instr_signal <= 1'b0;
      mc_instr_a      <= '0;
      mc_lsb_signal   <= 1'b0;
      mc_lsb_wr       <= 1'b0;
      mc_lsb_signed   <= 1'b0;
      mc_lsb_len      <= '0;
      mc_lsb_a        <= '0;
      mc_lsb_din      <= '0;
    end else if (rdy_in) begin
      if_ack  <= fin_if;
      lsb_ack <= fin_lsb;
      if (state == IDLE && !if_req)
        starve_cnt <= '0;
      if (grant_if) begin
        mc_instr_a      <= if_a;
        mc_instr_signal <= 1'b1;
        starve_cnt      <= '0;
      end
      if (grant_lsb) begin
        mc_lsb_wr     <= lsb_wr;
        mc_lsb_signed <= lsb_signed;
        mc_lsb_len    <= lsb_len;
        mc_lsb_a      <= lsb_a;
        mc_lsb_din    <= lsb_din;
        mc_lsb_signal <= 1'b1;
        if (if_req && starve_cnt != LIMIT)
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (fin_if) begin
        if_d            <= mc_instr_d;
        mc_instr_signal <= 1'b0;
      end
      if (fin_lsb) begin
        lsb_dout      <= mc_lsb_dout;
        mc_lsb_signal <= 1'b0;
      end
      if (abort) begin
        mc_instr_signal <= 1'b0;
        mc_lsb_signal   <= 1'b0;
      end
    end else begin
      // Frozen cycles never produce an ack; everything else holds.
      if_ack  <= 1'b0;
      lsb_ack <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with result scoreboard
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal;
  logic        if_req;
  logic [31:0] if_a;
  logic [63:0] if_d;
  logic        if_ack;
  logic        lsb_req, lsb_wr, lsb_signed;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_a, lsb_din, lsb_dout;
  logic        lsb_ack;
  logic        mc_instr_signal;
  logic [31:0] mc_instr_a;
  logic [63:0] mc_instr_d;
  logic        mc_instr_done;
  logic        mc_lsb_signal, mc_lsb_wr, mc_lsb_signed;
  logic [1:0]  mc_lsb_len;
  logic [31:0] mc_lsb_a, mc_lsb_din, mc_lsb_dout;
  logic        mc_lsb_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_if_q[$];
  logic [31:0] exp_lsb_q[$];
  int lsb_cnt, if_granted_at;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .if_req(if_req), .if_a(if_a), .if_d(if_d), .if_ack(if_ack),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_signed(lsb_signed), .lsb_len(lsb_len),
    .lsb_a(lsb_a), .lsb_din(lsb_din), .lsb_dout(lsb_dout), .lsb_ack(lsb_ack),
    .mc_instr_signal(mc_instr_signal), .mc_instr_a(mc_instr_a), .mc_instr_d(mc_instr_d),
    .mc_instr_done(mc_instr_done), .mc_lsb_signal(mc_lsb_signal), .mc_lsb_wr(mc_lsb_wr),
    .mc_lsb_signed(mc_lsb_signed), .mc_lsb_len(mc_lsb_len), .mc_lsb_a(mc_lsb_a),
    .mc_lsb_din(mc_lsb_din), .mc_lsb_dout(mc_lsb_dout), .mc_lsb_done(mc_lsb_done),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard: every ack must match the oldest pushed result.
  always @(negedge clk_in) begin
    chk("one_hot_mc", {63'd0, mc_instr_signal & mc_lsb_signal}, 64'd0);
    if (if_ack) begin
      if (exp_if_q.size() == 0) chk("unexpected_if_ack", 64'd1, 64'd0);
      else chk("if_d", if_d, exp_if_q.pop_front());
    end
    if (lsb_ack) begin
      if (exp_lsb_q.size() == 0) chk("unexpected_lsb_ack", 64'd1, 64'd0);
      else chk("lsb_dout", {32'd0, lsb_dout}, {32'd0, exp_lsb_q.pop_front()});
    end
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0;
    if_req = 1'b0; if_a = '0; lsb_req = 1'b0; lsb_wr = 1'b0; lsb_signed = 1'b0;
    lsb_len = 2'b00; lsb_a = '0; lsb_din = '0;
    mc_instr_d = '0; mc_instr_done = 1'b0; mc_lsb_dout = '0; mc_lsb_done = 1'b0;
    tick; tick;
    rst_in = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_lsb_ack", lsb_ack, 0);
    chk("rst_mc_instr_signal", mc_instr_signal, 0);
    chk("rst_mc_lsb_signal", mc_lsb_signal, 0);
    chk("rst_if_d", if_d, 0);
    chk("rst_mc_lsb_a", mc_lsb_a, 0);

    // Single fetch
    if_req = 1'b1; if_a = 32'h100;
    tick;
    chk("f1_signal", mc_instr_signal, 1);
    chk("f1_addr", mc_instr_a, 32'h100);
    chk("f1_busy", busy, 1);
    if_a = 32'hFFFF;
    tick;
    chk("f1_addr_held", mc_instr_a, 32'h100);
    mc_instr_d = 64'h0000_0013_0000_0093; mc_instr_done = 1'b1;
    exp_if_q.push_back(64'h0000_0013_0000_0093);
    tick;
    chk("f1_ack", if_ack, 1);
    chk("f1_signal_low", mc_instr_signal, 0);
    chk("f1_cool_busy", busy, 1);
    mc_instr_done = 1'b0; if_req = 1'b0; mc_instr_d = '0;
    tick;
    chk("f1_idle", busy, 0);
    chk("f1_ack_pulse", if_ack, 0);
    chk("f1_if_d_hold", if_d, 64'h0000_0013_0000_0093);

    // Contention: LSB first, then IF after COOL
    if_req = 1'b1; if_a = 32'h400;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b11; lsb_a = 32'h2000;
    tick;
    chk("c_lsb_first", mc_lsb_signal, 1);
    chk("c_if_wait", mc_instr_signal, 0);
    chk("c_lsb_a", mc_lsb_a, 32'h2000);
    mc_lsb_dout = 32'h1234_5678; mc_lsb_done = 1'b1;
    exp_lsb_q.push_back(32'h1234_5678);
    tick;
    chk("c_lsb_ack", lsb_ack, 1);
    mc_lsb_done = 1'b0; lsb_req = 1'b0;
    tick;
    chk("c_cool_no_if", mc_instr_signal, 0);
    tick;
    chk("c_if_granted", mc_instr_signal, 1);
    chk("c_if_addr", mc_instr_a, 32'h400);
    mc_instr_d = 64'h1111_2222_3333_4444; mc_instr_done = 1'b1;
    exp_if_q.push_back(64'h1111_2222_3333_4444);
    tick;
    chk("c_if_ack", if_ack, 1);
    mc_instr_done = 1'b0; if_req = 1'b0;
    tick; tick;

    // Starvation bound with back-to-back LSB traffic
    lsb_cnt = 0; if_granted_at = -1; if_a = 32'h800;
    for (int k = 0; k < 8 && lsb_cnt < 6; k++) begin
      lsb_req = 1'b1; lsb_a = 32'h3000 + 32'(k * 4);
      if_req = (if_granted_at < 0);
      tick;
      if (mc_lsb_signal) begin
        mc_lsb_dout = 32'hA000 + 32'(k); mc_lsb_done = 1'b1;
        exp_lsb_q.push_back(32'hA000 + 32'(k));
        tick;
        mc_lsb_done = 1'b0; lsb_req = 1'b0;
        lsb_cnt++;
        tick;
      end else if (mc_instr_signal) begin
        if_granted_at = lsb_cnt;
        mc_instr_d = 64'hB000 + 64'(k); mc_instr_done = 1'b1;
        exp_if_q.push_back(64'hB000 + 64'(k));
        tick;
        mc_instr_done = 1'b0; if_req = 1'b0;
        tick;
      end
    end
    lsb_req = 1'b0; if_req = 1'b0;
    chk("starve_if_after_4", 64'(if_granted_at), 64'd4);
    chk("starve_lsb_total", 64'(lsb_cnt), 64'd6);
    tick;

    // Flush in IDLE blocks grant; flush in G_IF aborts
    clear_signal = 1'b1; if_req = 1'b1; if_a = 32'hC00;
    tick;
    chk("clr_idle_no_grant", mc_instr_signal, 0);
    clear_signal = 1'b0;
    tick;
    chk("clr_if_granted", mc_instr_signal, 1);
    clear_signal = 1'b1;
    tick;
    chk("clr_if_dropped", mc_instr_signal, 0);
    chk("clr_if_idle", busy, 0);
    clear_signal = 1'b0; if_req = 1'b0;
    tick;

    // Flush load coinciding with done
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h5000;
    tick;
    chk("fl_granted", mc_lsb_signal, 1);
    clear_signal = 1'b1; mc_lsb_done = 1'b1; mc_lsb_dout = 32'h0BAD;
    tick;
    chk("fl_no_ack", lsb_ack, 0);
    chk("fl_signal_low", mc_lsb_signal, 0);
    chk("fl_idle", busy, 0);
    clear_signal = 1'b0; mc_lsb_done = 1'b0; lsb_req = 1'b0;
    tick;

    // Flush during store is ignored
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b11; lsb_din = 32'hDEADBEEF; lsb_a = 32'h6000;
    tick;
    chk("st_din", mc_lsb_din, 32'hDEADBEEF);
    chk("st_wr", mc_lsb_wr, 1);
    lsb_din = 32'h0; clear_signal = 1'b1;
    tick;
    chk("st_signal_kept", mc_lsb_signal, 1);
    chk("st_din_held", mc_lsb_din, 32'hDEADBEEF);
    mc_lsb_done = 1'b1; mc_lsb_dout = 32'h55;
    exp_lsb_q.push_back(32'h55);
    tick;
    chk("st_ack", lsb_ack, 1);
    chk("st_din_after", mc_lsb_din, 32'hDEADBEEF);
    clear_signal = 1'b0; mc_lsb_done = 1'b0; lsb_req = 1'b0; lsb_wr = 1'b0;
    tick; tick;

    // Freeze mid-G_IF
    if_req = 1'b1; if_a = 32'h900;
    tick;
    rdy_in = 1'b0; mc_instr_done = 1'b1; mc_instr_d = 64'hAAAA_5555_AAAA_5555;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("frz_signal", mc_instr_signal, 1);
      chk("frz_no_ack", if_ack, 0);
      chk("frz_busy", busy, 1);
      chk("frz_addr", mc_instr_a, 32'h900);
    end
    rdy_in = 1'b1;
    exp_if_q.push_back(64'hAAAA_5555_AAAA_5555);
    tick;
    chk("frz_ack_late", if_ack, 1);
    mc_instr_done = 1'b0; if_req = 1'b0;
    tick; tick;

    // Reset mid-G_LSB
    lsb_req = 1'b1; lsb_a = 32'h7000;
    tick;
    chk("rl_granted", mc_lsb_signal, 1);
    rst_in = 1'b1; mc_lsb_done = 1'b1; mc_lsb_dout = 32'h77;
    tick;
    chk("rl_signal", mc_lsb_signal, 0);
    chk("rl_ack", lsb_ack, 0);
    chk("rl_a", mc_lsb_a, 0);
    chk("rl_dout", lsb_dout, 0);
    chk("rl_if_d", if_d, 0);
    chk("rl_busy", busy, 0);
    rst_in = 1'b0; mc_lsb_done = 1'b0; lsb_req = 1'b0;
    tick;
    chk("rl_no_late_ack", lsb_ack, 0);
    tick;

    chk("if_queue_drained", 64'(exp_if_q.size()), 64'd0);
    chk("lsb_queue_drained", 64'(exp_lsb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory-controller port between the instruction fetcher (or i-cache) and the load/store buffer (LSB).
- Latches each requester's operands at grant and drives exactly one controller request at a time.
- Returns results with one-cycle acks, aborts squashable work on `clear_signal`, and bounds starvation of instruction fetch.

Parameters:
STARVE_LIMIT, 4, max consecutive LSB grants while if_req is pending before IF is forced (range 1..15)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes the block
clear_signal  in  1  misprediction flush
if_req  in  1  fetch request, held until if_ack
if_a  in  32  fetch address
if_d  out  64  fetched 8 bytes (2 instrs)
if_ack  out  1  one-cycle pulse, if_d valid
lsb_req  in  1  load/store request, held until lsb_ack
lsb_wr  in  1  1 = store
lsb_signed  in  1  signed load
lsb_len  in  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes
lsb_a  in  32  load/store address
lsb_din  in  32  store data
lsb_dout  out  32  load result
lsb_ack  out  1  one-cycle pulse, lsb_dout valid for loads
mc_instr_signal  out  1  fetch request to mem controller
mc_instr_a  out  32  latched fetch address
mc_instr_d  in  64  controller fetch data
mc_instr_done  in  1  controller fetch done
mc_lsb_signal  out  1  LSB request to mem controller
mc_lsb_wr, mc_lsb_signed  out  1 each  latched copies
mc_lsb_len  out  2  latched copy
mc_lsb_a, mc_lsb_din  out  32 each  latched copies
mc_lsb_dout  in  32  controller load data
mc_lsb_done  in  1  controller LSB done
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0. State IDLE, starve counter 0.
- Reset applies mid-transaction: the grant is dropped with no ack.
- rdy_in low: every register holds its value; no state transition; ack pulses are not generated that cycle.
- States:
  - IDLE: choose a requester.
  - G_IF: fetch outstanding.
  - G_LSB: load or store outstanding.
  - COOL: one cycle with both mc signals low.
- IDLE arbitration, evaluated only when clear_signal = 0:
  - Only one of if_req/lsb_req high: grant it.
  - Both high: LSB wins unless starve counter == STARVE_LIMIT, in which case IF wins.
  - Neither high: stay IDLE.
- Grant actions, applied on the clock edge of the IDLE decision cycle N:
  - Latch operands into the mc_* registers.
  - Assert the matching mc_*_signal from cycle N+1.
  - Operand changes after grant are ignored.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on an LSB grant while if_req = 1.
  - Clears on any IF grant.
  - Clears when if_req = 0 in IDLE.
- Completion: mc_*_done seen high in cycle M →
  - cycle M+1: corresponding ack = 1; if_d/lsb_dout register mc data; mc signal = 0; state COOL.
  - cycle M+2: state IDLE.
  - if_d/lsb_dout hold until the next ack.
- Requester protocol: the requester drops req (or presents a new request) in the cycle after ack. COOL guarantees no re-issue of the old request; minimum back-to-back spacing is 3 cycles.
- clear_signal = 1:
  - In G_IF: drop mc_instr_signal next cycle, go IDLE, no if_ack.
  - In G_LSB with load: drop the request, go IDLE, no lsb_ack.
  - In G_LSB with store: ignored; store completes and lsb_ack fires (committed stores are never squashed).
  - In IDLE: no grant that cycle.
- Simultaneous clear_signal and mc_*_done:
  - Fetch or load: the abort wins; no ack.
  - Store: ack as normal.
- mc_*_done for the non-granted side, or in IDLE/COOL: ignored.
- Exactly one of mc_instr_signal/mc_lsb_signal is high at any time, or neither.

Test Plan:
- Single fetch: if_req = 1, if_a = 0x100, controller done with 0x0000_0013_0000_0093 → if_ack exactly 1 cycle after done, if_d = that value, state IDLE 2 cycles after done.
- Contention: if_req = 1 and lsb_req = 1 (load, lsb_a = 0x2000) simultaneously → LSB granted first, IF granted after lsb_ack + COOL, mc_instr_a = if_a.
- Starvation: lsb_req back-to-back for 6 requests with if_req held, STARVE_LIMIT = 4 → IF granted after the 4th LSB ack, before the 5th LSB.
- Flush load: clear_signal during G_LSB load, same cycle as mc_lsb_done → no lsb_ack, mc_lsb_signal low next cycle, state IDLE.
- Flush store: clear_signal during a store (lsb_len = 11, lsb_din = 0xDEADBEEF) → store completes, lsb_ack pulses, mc_lsb_din unchanged throughout.
- Freeze/reset: rdy_in low for 3 cycles mid-G_IF → outputs and state frozen, ack delayed by 3 cycles. rst_in mid-G_LSB → all outputs 0 next cycle, no ack.
